// File: rtl/acc_isa_pkg.sv
// ISA, ALU-select, FSM state and error-code definitions for the accumulator processor.
// Shared by the control unit, the datapath and the bench.
package acc_isa_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS_B = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;
    localparam logic [2:0] ALU_NOT_A  = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMRD, S_MEMWR, S_EXEC, S_HALT
    } state_t;

    // ALU select for memory-operand instructions; LDA passes memory data through.
    function automatic logic [2:0] alu_for(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS_B;
        endcase
    endfunction

endpackage

// File: rtl/acc_mem_wait_timer.sv
// Counts consecutive ack-less cycles of a memory request; expired flags the
// TIMEOUT-th such cycle combinationally so the FSM can abort on that edge.
module acc_mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (cnt_en)
            cnt <= cnt + 1'b1;
    end

    assign expired = cnt_en && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/acc_ctrl_unit.sv
// Multicycle fetch/decode/execute sequencer for the 16-bit accumulator processor.
// Memory handshake: mem_rd/mem_wr stay high until a cycle with mem_ack, which completes the transfer.
module acc_ctrl_unit
    import acc_isa_pkg::*;
#(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  opcode,
    input  logic            acc_zero,
    input  logic            mem_ack,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            addr_sel,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            acc_load,
    output logic [2:0]      alu_op,
    output logic            halted,
    output logic [1:0]      err,
    output logic [CNTW-1:0] retired_cnt,
    output state_t          dbg_state
);
    state_t     state, state_next;
    logic       retire;
    logic [1:0] err_set;
    logic       in_wait;
    logic       expired;

    assign in_wait   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign dbg_state = state;

    // Timer is held at zero outside the wait states, so every entry starts from zero.
    acc_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_wait || mem_ack),
        .cnt_en  (in_wait && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            halted      <= 1'b0;
            err         <= ERR_NONE;
            retired_cnt <= '0;
        end else begin
            state  <= state_next;
            halted <= (state_next == S_HALT);
            if (err_set != ERR_NONE)
                err <= err_set;
            if (retire)
                retired_cnt <= retired_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        acc_load   = 1'b0;
        alu_op     = ALU_PASS_B;
        retire     = 1'b0;
        err_set    = ERR_NONE;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end else if (expired) begin
                    err_set    = ERR_TIMEOUT;
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_MEMRD;
                    OP_STA: state_next = S_MEMWR;
                    OP_NOT: state_next = S_EXEC;
                    OP_JMP: begin
                        pc_load    = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JZ: begin
                        pc_load    = acc_zero;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_NOP: begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_HLT: begin
                        retire     = 1'b1;
                        state_next = S_HALT;
                    end
                    default: begin
                        err_set    = ERR_ILLEGAL;
                        state_next = S_HALT;
                    end
                endcase
            end
            S_MEMRD: begin
                mem_rd   = 1'b1;
                addr_sel = 1'b1;
                alu_op   = alu_for(opcode);
                if (mem_ack) begin
                    acc_load   = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (expired) begin
                    err_set    = ERR_TIMEOUT;
                    state_next = S_HALT;
                end
            end
            S_MEMWR: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (expired) begin
                    err_set    = ERR_TIMEOUT;
                    state_next = S_HALT;
                end
            end
            S_EXEC: begin
                alu_op     = ALU_NOT_A;
                acc_load   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_acc_ctrl_unit.sv
// Bench for acc_ctrl_unit: per-instruction expected strobe traces built from the ISA rules,
// replayed cycle by cycle with randomized memory latency and opcodes.
module tb_acc_ctrl_unit;
    import acc_isa_pkg::*;

    localparam int TO = 15;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    opcode = 4'h0;
    logic          acc_zero = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load;
    logic [2:0]    alu_op;
    logic          halted;
    logic [1:0]    err;
    logic [CW-1:0] retired_cnt;
    state_t        dbg_state;

    acc_ctrl_unit #(.OPW(4), .TIMEOUT(TO), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .acc_zero(acc_zero),
        .mem_ack(mem_ack), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load),
        .alu_op(alu_op), .halted(halted), .err(err), .retired_cnt(retired_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [9:0] obs_vec;
    assign obs_vec = {mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op};

    logic [9:0] exp_q[$];
    logic [9:0] msk_q[$];
    logic       ack_q[$];

    int         n_vec = 0;
    int         n_fail = 0;
    int         model_cnt = 0;
    logic       model_halt = 1'b0;
    logic [1:0] model_err = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] sv(input logic rd, input logic wr, input logic as,
                                      input logic ir, input logic inc, input logic pl,
                                      input logic al, input logic [2:0] op);
        return {rd, wr, as, ir, inc, pl, al, op};
    endfunction

    task automatic push(input logic [9:0] v, input logic care_alu, input logic ack);
        exp_q.push_back(v);
        msk_q.push_back(care_alu ? 10'h3ff : 10'h3f8);
        ack_q.push_back(ack);
    endtask

    task automatic retire_m();
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    // Memory phase: md ack-less cycles then the ack; md >= TO aborts with a bus timeout.
    task automatic mem_phase(input logic wr, input logic [2:0] a, input int md);
        int n;
        n = (md >= TO) ? TO : md;
        for (int k = 0; k < n; k++)
            push(sv(!wr, wr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a), !wr, 1'b0);
        if (md >= TO) begin
            model_halt = 1'b1;
            model_err  = ERR_TIMEOUT;
        end else begin
            push(sv(!wr, wr, 1'b1, 1'b0, 1'b0, 1'b0, !wr, a), !wr, 1'b1);
            retire_m();
        end
    endtask

    task automatic build(input logic [3:0] op, input logic az, input int fd, input int md);
        logic [2:0] a;
        exp_q.delete();
        msk_q.delete();
        ack_q.delete();
        if (fd >= TO) begin
            for (int k = 0; k < TO; k++)
                push(sv(1, 0, 0, 0, 0, 0, 0, 3'd0), 1'b0, 1'b0);
            model_halt = 1'b1;
            model_err  = ERR_TIMEOUT;
            return;
        end
        for (int k = 0; k < fd; k++)
            push(sv(1, 0, 0, 0, 0, 0, 0, 3'd0), 1'b0, 1'b0);
        push(sv(1, 0, 0, 1, 1, 0, 0, 3'd0), 1'b0, 1'b1);
        case (op)
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
                a = (op == 4'h1) ? 3'd0 : 3'(op - 4'h2);
                push(10'h000, 1'b0, 1'($urandom_range(0, 1)));
                mem_phase(1'b0, a, md);
            end
            4'h2: begin
                push(10'h000, 1'b0, 1'($urandom_range(0, 1)));
                mem_phase(1'b1, 3'd0, md);
            end
            4'h7: begin
                push(10'h000, 1'b0, 1'($urandom_range(0, 1)));
                push(sv(0, 0, 0, 0, 0, 0, 1, 3'd5), 1'b1, 1'($urandom_range(0, 1)));
                retire_m();
            end
            4'h8: begin push(sv(0, 0, 0, 0, 0, 1, 0, 3'd0), 1'b0, 1'($urandom_range(0, 1))); retire_m(); end
            4'h9: begin push(sv(0, 0, 0, 0, 0, az, 0, 3'd0), 1'b0, 1'($urandom_range(0, 1))); retire_m(); end
            4'h0: begin push(10'h000, 1'b0, 1'($urandom_range(0, 1))); retire_m(); end
            4'hF: begin
                push(10'h000, 1'b0, 1'($urandom_range(0, 1)));
                retire_m();
                model_halt = 1'b1;
            end
            default: begin
                push(10'h000, 1'b0, 1'($urandom_range(0, 1)));
                model_halt = 1'b1;
                model_err  = ERR_ILLEGAL;
            end
        endcase
    endtask

    task automatic run_instr(input logic [3:0] op, input logic az, input int fd, input int md);
        opcode   = op;
        acc_zero = az;
        build(op, az, fd, md);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            mem_ack = ack_q[i];
            #1;
            check($sformatf("op%0h_cyc%0d", op, i), 32'(obs_vec & msk_q[i]), 32'(exp_q[i]));
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check($sformatf("op%0h_cnt", op), 32'(retired_cnt), 32'(model_cnt));
        check($sformatf("op%0h_halted", op), 32'(halted), 32'(model_halt));
        check($sformatf("op%0h_err", op), 32'(err), 32'(model_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_cnt  = 0;
        model_halt = 1'b0;
        model_err  = ERR_NONE;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_ignored(input string tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start   = 1'($urandom_range(0, 1));
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            check({tag, "_strobes"}, 32'(obs_vec & 10'h3f8), 32'h0);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        mem_ack = 1'b0;
        check({tag, "_halted"}, 32'(halted), 32'(model_halt));
        check({tag, "_err"}, 32'(err), 32'(model_err));
        check({tag, "_cnt"}, 32'(retired_cnt), 32'(model_cnt));
        check({tag, "_state"}, 32'(dbg_state), 32'(S_HALT));
    endtask

    initial begin
        #12;
        check("rst_strobes", 32'(obs_vec & 10'h3f8), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_cnt", 32'(retired_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            check("idle_strobes", 32'(obs_vec & 10'h3f8), 32'h0);
        end
        mem_ack = 1'b0;
        check("idle_state", 32'(dbg_state), 32'(S_IDLE));

        start_pulse();
        run_instr(OP_LDA, 1'b0, 0, 0);
        run_instr(OP_ADD, 1'b0, 0, 0);
        run_instr(OP_STA, 1'b0, 0, 4);
        run_instr(OP_JZ,  1'b1, 0, 0);
        run_instr(OP_JZ,  1'b0, 1, 0);
        run_instr(OP_NOT, 1'b0, 0, 0);
        run_instr(OP_JMP, 1'b0, 2, 0);
        run_instr(OP_NOP, 1'b0, 0, 0);
        run_instr(OP_LDA, 1'b0, TO - 1, TO - 1);

        for (int n = 0; n < 120; n++) begin
            int fd, md;
            fd = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 3);
            md = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 3);
            run_instr(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), fd, md);
        end

        // Asynchronous reset in the middle of a MEMRD request.
        opcode = OP_LDA;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("memrd_req", 32'({mem_rd, addr_sel}), 32'h3);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_strobes", 32'(obs_vec & 10'h3f8), 32'h0);
        check("async_rst_halted", 32'(halted), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);
        check("async_rst_cnt", 32'(retired_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_cnt  = 0;
        model_halt = 1'b0;
        model_err  = ERR_NONE;
        start_pulse();
        run_instr(OP_NOP, 1'b0, 0, 0);
        run_instr(OP_HLT, 1'b0, 1, 0);
        check_ignored("hlt");

        do_reset();
        start_pulse();
        run_instr(4'hB, 1'b0, 0, 0);
        check_ignored("ill_b");

        do_reset();
        start_pulse();
        run_instr(OP_NOP, 1'b0, 0, 0);
        run_instr(4'($urandom_range(10, 14)), 1'b0, 0, 0);

        do_reset();
        start_pulse();
        run_instr(OP_NOP, 1'b0, TO, 0);
        check_ignored("to_fetch");

        do_reset();
        start_pulse();
        run_instr(OP_ADD, 1'b0, 0, TO);

        do_reset();
        start_pulse();
        run_instr(OP_STA, 1'b0, 1, TO);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
